// File: rtl/spram_arbiter_if.sv
// Requester-side bundle of the SPRAM arbiter: two request channels and tagged read returns.
interface spram_arbiter_if #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 8
);
    logic              rq0_req;
    logic              rq1_req;
    logic              rq0_we;
    logic              rq1_we;
    logic [ADDR_W-1:0] rq0_addr;
    logic [ADDR_W-1:0] rq1_addr;
    logic [DATA_W-1:0] rq0_wdata;
    logic [DATA_W-1:0] rq1_wdata;
    logic              rq0_lock;
    logic              rq1_lock;
    logic              rq0_gnt;
    logic              rq1_gnt;
    logic              rq0_rvalid;
    logic              rq1_rvalid;
    logic [DATA_W-1:0] rdata;

    // Requester view
    modport master (
        output rq0_req, rq1_req, rq0_we, rq1_we, rq0_addr, rq1_addr,
               rq0_wdata, rq1_wdata, rq0_lock, rq1_lock,
        input  rq0_gnt, rq1_gnt, rq0_rvalid, rq1_rvalid, rdata
    );

    // Arbiter view
    modport slave (
        input  rq0_req, rq1_req, rq0_we, rq1_we, rq0_addr, rq1_addr,
               rq0_wdata, rq1_wdata, rq0_lock, rq1_lock,
        output rq0_gnt, rq1_gnt, rq0_rvalid, rq1_rvalid, rdata
    );
endinterface

// File: rtl/spram_arbiter.sv
// Round-robin arbiter with bounded burst lock sharing one single-port byte SPRAM
// between two requesters; read data is returned tagged to the issuing requester.
module spram_arbiter #(
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    spram_arbiter_if.slave    rq,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);
    localparam int unsigned      CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    logic              last_q, last_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_write_q, mem_write_d;
    logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
    logic              tag1_valid_q, tag1_valid_d;
    logic              tag1_id_q, tag1_id_d;
    logic              tag2_valid_q, tag2_valid_d;
    logic              tag2_id_q, tag2_id_d;

    logic              gnt_any;
    logic              gnt_id;
    logic              lock_last;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Grant decision: single requester wins outright, contention honours a bounded lock, else round-robin
    always_comb begin
        gnt_any   = 1'b0;
        gnt_id    = 1'b0;
        lock_last = last_q ? rq.rq1_lock : rq.rq0_lock;
        case ({rq.rq1_req, rq.rq0_req})
            2'b01: begin
                gnt_any = 1'b1;
                gnt_id  = 1'b0;
            end
            2'b10: begin
                gnt_any = 1'b1;
                gnt_id  = 1'b1;
            end
            2'b11: begin
                gnt_any = 1'b1;
                gnt_id  = (lock_last && (burst_cnt_q < BURST_MAX)) ? last_q : ~last_q;
            end
            default: begin
                gnt_any = 1'b0;
                gnt_id  = 1'b0;
            end
        endcase
    end

    // Mux the granted requester's access fields
    always_comb begin
        sel_we    = gnt_id ? rq.rq1_we    : rq.rq0_we;
        sel_addr  = gnt_id ? rq.rq1_addr  : rq.rq0_addr;
        sel_wdata = gnt_id ? rq.rq1_wdata : rq.rq0_wdata;
    end

    // Next state: memory command, ownership/burst tracking, read-tag pipeline
    always_comb begin
        last_d        = last_q;
        burst_cnt_d   = '0;
        mem_addr_d    = mem_addr_q;
        mem_write_d   = 1'b0;
        mem_data_in_d = mem_data_in_q;
        tag1_valid_d  = 1'b0;
        tag1_id_d     = tag1_id_q;
        tag2_valid_d  = tag1_valid_q;
        tag2_id_d     = tag1_id_q;
        if (gnt_any) begin
            mem_addr_d    = sel_addr;
            mem_write_d   = sel_we;
            mem_data_in_d = sel_wdata;
            tag1_valid_d  = ~sel_we;
            tag1_id_d     = gnt_id;
            if (gnt_id == last_q) begin
                burst_cnt_d = (burst_cnt_q >= BURST_MAX) ? BURST_MAX : burst_cnt_q + CNT_W'(1);
            end else begin
                burst_cnt_d = CNT_W'(1);
                last_d      = gnt_id;
            end
        end
    end

    // State registers; last resets to 1 so requester 0 wins the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q        <= 1'b1;
            burst_cnt_q   <= '0;
            mem_addr_q    <= '0;
            mem_write_q   <= 1'b0;
            mem_data_in_q <= '0;
            tag1_valid_q  <= 1'b0;
            tag1_id_q     <= 1'b0;
            tag2_valid_q  <= 1'b0;
            tag2_id_q     <= 1'b0;
        end else begin
            last_q        <= last_d;
            burst_cnt_q   <= burst_cnt_d;
            mem_addr_q    <= mem_addr_d;
            mem_write_q   <= mem_write_d;
            mem_data_in_q <= mem_data_in_d;
            tag1_valid_q  <= tag1_valid_d;
            tag1_id_q     <= tag1_id_d;
            tag2_valid_q  <= tag2_valid_d;
            tag2_id_q     <= tag2_id_d;
        end
    end

    assign rq.rq0_gnt    = rst_n & gnt_any & ~gnt_id;
    assign rq.rq1_gnt    = rst_n & gnt_any & gnt_id;
    assign rq.rq0_rvalid = tag2_valid_q & ~tag2_id_q;
    assign rq.rq1_rvalid = tag2_valid_q & tag2_id_q;
    assign rq.rdata      = mem_data_out;
    assign mem_addr      = mem_addr_q;
    assign mem_write     = mem_write_q;
    assign mem_data_in   = mem_data_in_q;
endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: behavioural SPRAM, grant/read-return scoreboard, scenario tasks.
module tb_spram_arbiter;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    spram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rif ();

    spram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rq           (rif),
        .mem_addr     (mem_addr),
        .mem_write    (mem_write),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    // Behavioural SPRAM: registered command, one-cycle read latency
    logic [7:0] mem_arr [32768];
    always @(posedge clk) begin
        if (mem_write) mem_arr[mem_addr] <= mem_data_in;
        mem_data_out <= mem_arr[mem_addr];
    end

    typedef struct {
        logic       id;
        logic [7:0] data;
        int         due;
    } exp_t;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         rv0_cnt = 0;
    int         rv1_cnt = 0;
    exp_t       sb[$];
    logic       glog[$];
    logic [7:0] ref_mem [32768];

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: log grants, predict reads, check every returned read
    always @(negedge clk) begin : mon
        exp_t             e;
        logic             id;
        logic [ADDR_W-1:0] a;
        if (rst_n === 1'b1) begin
            if (rif.rq0_rvalid || rif.rq1_rvalid) begin
                if (rif.rq0_rvalid) rv0_cnt++;
                if (rif.rq1_rvalid) rv1_cnt++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL rvalid_unexpected: rv0=%0b rv1=%0b with nothing outstanding at cyc %0d",
                             rif.rq0_rvalid, rif.rq1_rvalid, cyc);
                end else begin
                    e = sb.pop_front();
                    if ((rif.rq0_rvalid && rif.rq1_rvalid) || rif.rq1_rvalid !== e.id ||
                        rif.rdata !== e.data || cyc != e.due) begin
                        bad++;
                        $display("FAIL read_return: got rv0=%0b rv1=%0b data=%h cyc=%0d, need id=%0b data=%h cyc=%0d",
                                 rif.rq0_rvalid, rif.rq1_rvalid, rif.rdata, cyc, e.id, e.data, e.due);
                    end
                end
            end else if (sb.size() > 0 && sb[0].due < cyc) begin
                total++;
                bad++;
                e = sb.pop_front();
                $display("FAIL read_missing: no rvalid at cyc %0d, need id=%0b data=%h", e.due, e.id, e.data);
            end
            if (rif.rq0_gnt && rif.rq1_gnt) begin
                total++;
                bad++;
                $display("FAIL double_grant: gnt0=1 gnt1=1, need at most one");
            end
            if (rif.rq0_gnt || rif.rq1_gnt) begin
                id = rif.rq1_gnt;
                glog.push_back(id);
                a = id ? rif.rq1_addr : rif.rq0_addr;
                if (id ? rif.rq1_we : rif.rq0_we)
                    ref_mem[a] = id ? rif.rq1_wdata : rif.rq0_wdata;
                else
                    sb.push_back('{id: id, data: ref_mem[a], due: cyc + 2});
            end
        end
    end

    task automatic idle_inputs();
        rif.rq0_req = 1'b0; rif.rq0_we = 1'b0; rif.rq0_addr = '0; rif.rq0_wdata = '0; rif.rq0_lock = 1'b0;
        rif.rq1_req = 1'b0; rif.rq1_we = 1'b0; rif.rq1_addr = '0; rif.rq1_wdata = '0; rif.rq1_lock = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        rif.rq0_req = 1'b1; rif.rq0_we = 1'b1; rif.rq0_addr = 15'h100; rif.rq0_wdata = 8'h11;
        repeat (2) @(negedge clk);
        total++;
        if ({rif.rq0_gnt, rif.rq1_gnt, rif.rq0_rvalid, rif.rq1_rvalid, mem_write} !== 5'b0 ||
            mem_addr !== '0 || mem_data_in !== '0) begin
            bad++;
            $display("FAIL reset_values: gnt=%b%b rv=%b%b wr=%b addr=%h din=%h, need all 0",
                     rif.rq0_gnt, rif.rq1_gnt, rif.rq0_rvalid, rif.rq1_rvalid, mem_write, mem_addr, mem_data_in);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rif.rq0_addr = 15'h101; rif.rq0_wdata = 8'h12;
        @(posedge clk); #1;
        total++;
        if (mem_write !== 1'b1) begin
            bad++;
            $display("FAIL reset_burst_active: mem_write=%b, need 1", mem_write);
        end
        rst_n = 1'b0;
        sb.delete();
        #1;
        total++;
        if (mem_write !== 1'b0 || mem_addr !== '0 || mem_data_in !== '0 || rif.rq0_gnt !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: wr=%b addr=%h din=%h gnt0=%b, need 0 0 0 0",
                     mem_write, mem_addr, mem_data_in, rif.rq0_gnt);
        end
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        rif.rq0_req = 1'b1; rif.rq0_we = 1'b0; rif.rq0_addr = 15'h100;
        @(posedge clk); #1;
        idle_inputs();
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (rif.rq0_rvalid !== 1'b0 || rif.rq1_rvalid !== 1'b0) begin
                bad++;
                $display("FAIL reset_discard: rv0=%b rv1=%b cycle %0d after release, need 0 0",
                         rif.rq0_rvalid, rif.rq1_rvalid, i);
            end
        end
    endtask

    task automatic test_single();
        int base;
        base = rv0_cnt;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            rif.rq0_req = 1'b1; rif.rq0_we = 1'b1; rif.rq0_addr = 15'(i); rif.rq0_wdata = 8'h41 + 8'(i);
            @(negedge clk);
            total++;
            if (rif.rq0_gnt !== 1'b1) begin
                bad++;
                $display("FAIL single_wr_gnt: gnt0=%b on write %0d, need 1", rif.rq0_gnt, i);
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 4; i++) begin
            rif.rq0_we = 1'b0; rif.rq0_addr = 15'(i);
            @(negedge clk);
            total++;
            if (rif.rq0_gnt !== 1'b1) begin
                bad++;
                $display("FAIL single_rd_gnt: gnt0=%b on read %0d, need 1", rif.rq0_gnt, i);
            end
            @(posedge clk); #1;
            if (i == 0) begin
                total++;
                if (mem_write !== 1'b0) begin
                    bad++;
                    $display("FAIL single_wr_drop: mem_write=%b after last write, need 0", mem_write);
                end
            end
        end
        idle_inputs();
        repeat (4) @(negedge clk);
        total++;
        if (rv0_cnt - base != 4 || sb.size() != 0) begin
            bad++;
            $display("FAIL single_rd_count: rvalid0 count=%0d pending=%0d, need 4 and 0", rv0_cnt - base, sb.size());
        end
    endtask

    task automatic test_contention();
        int  n0, n1, b;
        logic g0, g1;
        do_reset();
        b = glog.size();
        n0 = 0; n1 = 0;
        rif.rq0_req = 1'b1; rif.rq0_addr = 15'd0;
        rif.rq1_req = 1'b1; rif.rq1_addr = 15'd3;
        for (int c = 0; c < 20 && (n0 < 4 || n1 < 4); c++) begin
            @(negedge clk);
            g0 = rif.rq0_gnt; g1 = rif.rq1_gnt;
            @(posedge clk); #1;
            if (g0) begin n0++; if (n0 == 4) rif.rq0_req = 1'b0; else rif.rq0_addr = 15'(n0); end
            if (g1) begin n1++; if (n1 == 4) rif.rq1_req = 1'b0; else rif.rq1_addr = 15'(3 - n1); end
        end
        idle_inputs();
        repeat (4) @(negedge clk);
        total++;
        if (n0 != 4 || n1 != 4 || glog.size() < b + 8) begin
            bad++;
            $display("FAIL contention_done: grants0=%0d grants1=%0d, need 4 and 4", n0, n1);
        end else begin
            for (int k = 0; k < 8; k++) begin
                total++;
                if (glog[b + k] !== 1'(k % 2)) begin
                    bad++;
                    $display("FAIL contention_order: grant %0d went to %0b, need %0b", k, glog[b + k], 1'(k % 2));
                end
            end
        end
    endtask

    task automatic test_lock();
        int  n0, n1, b;
        logic g0, g1;
        do_reset();
        b = glog.size();
        n0 = 0; n1 = 0;
        rif.rq1_req = 1'b1; rif.rq1_lock = 1'b1; rif.rq1_addr = 15'd0;
        rif.rq0_req = 1'b1; rif.rq0_addr = 15'd3;
        for (int c = 0; c < 20 && (n0 < 1 || n1 < 5); c++) begin
            @(negedge clk);
            g0 = rif.rq0_gnt; g1 = rif.rq1_gnt;
            @(posedge clk); #1;
            if (g0) begin n0++; rif.rq0_req = 1'b0; end
            if (g1) begin
                n1++;
                if (n1 == 5) begin rif.rq1_req = 1'b0; rif.rq1_lock = 1'b0; end
                else rif.rq1_addr = 15'(n1 % 4);
            end
        end
        idle_inputs();
        repeat (4) @(negedge clk);
        total++;
        if (n0 != 1 || n1 != 5 || glog.size() < b + 6) begin
            bad++;
            $display("FAIL lock_done: grants0=%0d grants1=%0d, need 1 and 5", n0, n1);
        end else begin
            for (int k = 0; k < 6; k++) begin
                total++;
                if (glog[b + k] !== ((k == 4) ? 1'b0 : 1'b1)) begin
                    bad++;
                    $display("FAIL lock_order: grant %0d went to %0b, need %0b", k, glog[b + k], (k == 4) ? 1'b0 : 1'b1);
                end
            end
        end
    endtask

    task automatic test_raw();
        bit seen;
        rif.rq0_req = 1'b1; rif.rq0_we = 1'b1; rif.rq0_addr = 15'h7FFF; rif.rq0_wdata = 8'h5A;
        @(negedge clk);
        total++;
        if (rif.rq0_gnt !== 1'b1) begin
            bad++;
            $display("FAIL raw_wr_gnt: gnt0=%b, need 1", rif.rq0_gnt);
        end
        @(posedge clk); #1;
        idle_inputs();
        rif.rq1_req = 1'b1; rif.rq1_we = 1'b0; rif.rq1_addr = 15'h7FFF;
        @(negedge clk);
        total++;
        if (rif.rq1_gnt !== 1'b1) begin
            bad++;
            $display("FAIL raw_rd_gnt: gnt1=%b, need 1", rif.rq1_gnt);
        end
        @(posedge clk); #1;
        idle_inputs();
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            if (rif.rq1_rvalid === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen || rif.rdata !== 8'h5A) begin
            bad++;
            $display("FAIL raw_data: rvalid1 seen=%0b rdata=%h, need 1 and 5a", seen, rif.rdata);
        end
    endtask

    task automatic test_abandon();
        rif.rq0_req = 1'b1; rif.rq0_we = 1'b1; rif.rq0_lock = 1'b1; rif.rq0_addr = 15'h200; rif.rq0_wdata = 8'h77;
        @(negedge clk);
        @(posedge clk); #1;
        rif.rq0_addr = 15'h201; rif.rq0_wdata = 8'h78;
        rif.rq1_req = 1'b1; rif.rq1_we = 1'b0; rif.rq1_addr = 15'd2;
        @(negedge clk);
        total++;
        if (rif.rq1_gnt !== 1'b0 || rif.rq0_gnt !== 1'b1) begin
            bad++;
            $display("FAIL abandon_locked: gnt0=%b gnt1=%b, need 1 0", rif.rq0_gnt, rif.rq1_gnt);
        end
        @(posedge clk); #1;
        rif.rq1_req = 1'b0;
        rif.rq0_addr = 15'h202; rif.rq0_wdata = 8'h79;
        @(negedge clk);
        total++;
        if (rif.rq1_gnt !== 1'b0 || rif.rq0_gnt !== 1'b1) begin
            bad++;
            $display("FAIL abandon_dropped: gnt0=%b gnt1=%b, need 1 0", rif.rq0_gnt, rif.rq1_gnt);
        end
        @(posedge clk); #1;
        total++;
        if (mem_write !== 1'b1) begin
            bad++;
            $display("FAIL abandon_wr_active: mem_write=%b, need 1", mem_write);
        end
        idle_inputs();
        @(negedge clk);
        total++;
        if (rif.rq0_gnt !== 1'b0 || rif.rq1_gnt !== 1'b0) begin
            bad++;
            $display("FAIL idle_gnt: gnt0=%b gnt1=%b, need 0 0", rif.rq0_gnt, rif.rq1_gnt);
        end
        @(posedge clk); #1;
        total++;
        if (dut.burst_cnt_q !== '0 || mem_write !== 1'b0 || mem_addr !== 15'h202) begin
            bad++;
            $display("FAIL idle_state: burst_cnt=%0d mem_write=%b mem_addr=%h, need 0 0 202",
                     dut.burst_cnt_q, mem_write, mem_addr);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_lock();
        test_raw();
        test_abandon();
        repeat (4) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL final_drain: %0d reads outstanding, need 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
